// File: rtl/monitor_pkg.sv
// monitor_pkg: shared state encoding and per-location write-count type for sram_write_monitor
package monitor_pkg;
  typedef enum logic [2:0] {
    S_MON_IDLE,
    S_MON_CLEAR,
    S_MON_MONITOR,
    S_MON_SWEEP,
    S_MON_REPORT
  } mon_state_e;
  typedef logic [1:0] wcnt_t;
endpackage

// File: rtl/mon_dp_ram.sv
// mon_dp_ram: single-clock synchronous RAM with one write and one registered read port
module mon_dp_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];
  // write port and read-before-write registered read
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/sram_write_monitor.sv
// sram_write_monitor: checks snooped SRAM writes against an expected image; optional halt via MON_STOP_ON_LIMIT_EN
module sram_write_monitor
  import monitor_pkg::*;
#(
  parameter int ADDR_W         = 18,
  parameter int DATA_W         = 16,
  parameter int REGION_BASE    = 0,
  parameter int REGION_LIMIT   = 76799,
  parameter int CNT_W          = 16,
  parameter int MAX_MISMATCHES = 20
) (
  input  logic              Clock_50,
  input  logic              Reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_address,
  input  logic [DATA_W-1:0] load_data,
  input  logic              mon_start,
  input  logic              mon_done,
  input  logic              SRAM_we_n,
  input  logic [ADDR_W-1:0] SRAM_address,
  input  logic [DATA_W-1:0] SRAM_write_data,
  output logic              busy,
  output logic              report_valid,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic [CNT_W-1:0]  oor_count,
  output logic [CNT_W-1:0]  multi_write_count,
  output logic [CNT_W-1:0]  unwritten_count,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_address,
  output logic [DATA_W-1:0] first_err_data,
  output logic [DATA_W-1:0] first_err_expected,
  output logic              halt
);
`ifdef MON_STOP_ON_LIMIT_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(REGION_BASE);
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(REGION_LIMIT - REGION_BASE);
  mon_state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, s1_addr_q, s1_addr_d, first_err_address_q, first_err_address_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d, first_err_data_q, first_err_data_d, first_err_expected_q, first_err_expected_d;
  logic [CNT_W-1:0] mismatch_count_q, mismatch_count_d, oor_count_q, oor_count_d;
  logic [CNT_W-1:0] multi_write_count_q, multi_write_count_d, unwritten_count_q, unwritten_count_d;
  logic tail_q, tail_d, drain_q, drain_d, s1_valid_q, s1_valid_d, s1_inr_q, s1_inr_d;
  logic fwd_q, fwd_d, sw_valid_q, sw_valid_d, first_err_valid_q, first_err_valid_d, halt_q, halt_d;
  wcnt_t fwd_cnt_q, fwd_cnt_d, cnt_rdata, cnt_old, cnt_new, cnt_wdata;
  logic [DATA_W-1:0] exp_rdata;
  logic [ADDR_W-1:0] cnt_waddr, cnt_raddr;
  logic stop, sample, upd, mism, cnt_we, in_clear;
  mon_dp_ram #(.AW(ADDR_W), .DW(DATA_W)) u_exp (
    .clk(Clock_50), .we(load_en && state_q == S_MON_IDLE), .waddr(load_address),
    .wdata(load_data), .raddr(SRAM_address), .rdata(exp_rdata)
  );
  mon_dp_ram #(.AW(ADDR_W), .DW(2)) u_cnt (
    .clk(Clock_50), .we(cnt_we), .waddr(cnt_waddr), .wdata(cnt_wdata),
    .raddr(cnt_raddr), .rdata(cnt_rdata)
  );
  // stage 1 sampling, stage 2 compare/write-back with same-address forwarding, and memory port muxing
  always_comb begin
    in_clear   = state_q == S_MON_CLEAR;
    stop       = halt_q || (STOP_EN && mismatch_count_q >= CNT_W'(MAX_MISMATCHES));
    sample     = state_q == S_MON_MONITOR && !drain_q && !SRAM_we_n && !stop;
    s1_valid_d = sample;
    s1_inr_d   = (SRAM_address - BASE) <= SPAN;
    s1_addr_d  = SRAM_address;
    s1_data_d  = SRAM_write_data;
    upd        = s1_valid_q && !stop && s1_inr_q;
    mism       = upd && s1_data_q != exp_rdata;
    cnt_old    = fwd_q ? fwd_cnt_q : cnt_rdata;
    cnt_new    = cnt_old == 2'd3 ? 2'd3 : cnt_old + 2'd1;
    fwd_d      = upd && sample && SRAM_address == s1_addr_q;
    fwd_cnt_d  = cnt_new;
    cnt_we     = (in_clear && !tail_q) || upd;
    cnt_waddr  = in_clear ? addr_q : s1_addr_q;
    cnt_wdata  = in_clear ? 2'd0 : cnt_new;
    cnt_raddr  = state_q == S_MON_SWEEP ? addr_q : SRAM_address;
  end
  // sequencing through clear/monitor/sweep plus saturating report counters
  always_comb begin
    state_d              = state_q;
    addr_d               = addr_q;
    tail_d               = tail_q;
    drain_d              = drain_q;
    sw_valid_d           = 1'b0;
    mismatch_count_d     = (mism && ~&mismatch_count_q) ? mismatch_count_q + 1'b1 : mismatch_count_q;
    oor_count_d          = (s1_valid_q && !stop && !s1_inr_q && ~&oor_count_q) ? oor_count_q + 1'b1 : oor_count_q;
    multi_write_count_d  = (upd && cnt_old != 2'd0 && ~&multi_write_count_q) ? multi_write_count_q + 1'b1 : multi_write_count_q;
    unwritten_count_d    = (sw_valid_q && cnt_rdata == 2'd0 && ~&unwritten_count_q) ? unwritten_count_q + 1'b1 : unwritten_count_q;
    first_err_valid_d    = first_err_valid_q || mism;
    first_err_address_d  = (mism && !first_err_valid_q) ? s1_addr_q : first_err_address_q;
    first_err_data_d     = (mism && !first_err_valid_q) ? s1_data_q : first_err_data_q;
    first_err_expected_d = (mism && !first_err_valid_q) ? exp_rdata : first_err_expected_q;
    halt_d               = halt_q || (STOP_EN && mismatch_count_q >= CNT_W'(MAX_MISMATCHES));
    case (state_q)
      S_MON_IDLE, S_MON_REPORT: begin
        if (mon_start) begin
          state_d = S_MON_CLEAR;
          addr_d  = BASE;
          tail_d  = 1'b0;
        end
      end
      S_MON_CLEAR: begin
        mismatch_count_d     = '0;
        oor_count_d          = '0;
        multi_write_count_d  = '0;
        unwritten_count_d    = '0;
        first_err_valid_d    = 1'b0;
        first_err_address_d  = '0;
        first_err_data_d     = '0;
        first_err_expected_d = '0;
        halt_d               = 1'b0;
        if (tail_q) begin
          state_d = S_MON_MONITOR;
          drain_d = 1'b0;
        end else if (addr_q == BASE + SPAN) tail_d = 1'b1;
        else addr_d = addr_q + 1'b1;
      end
      S_MON_MONITOR: begin
        if (drain_q) begin
          state_d = S_MON_SWEEP;
          addr_d  = BASE;
          tail_d  = 1'b0;
        end else if (mon_done) drain_d = 1'b1;
      end
      S_MON_SWEEP: begin
        if (tail_q) state_d = S_MON_REPORT;
        else begin
          sw_valid_d = 1'b1;
          if (addr_q == BASE + SPAN) tail_d = 1'b1;
          else addr_d = addr_q + 1'b1;
        end
      end
      default: state_d = S_MON_IDLE;
    endcase
  end
  // state and pipeline registers; reset returns to IDLE with all outputs cleared
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state_q              <= S_MON_IDLE;
      addr_q               <= '0;
      tail_q               <= 1'b0;
      drain_q              <= 1'b0;
      sw_valid_q           <= 1'b0;
      s1_valid_q           <= 1'b0;
      s1_inr_q             <= 1'b0;
      s1_addr_q            <= '0;
      s1_data_q            <= '0;
      fwd_q                <= 1'b0;
      fwd_cnt_q            <= '0;
      mismatch_count_q     <= '0;
      oor_count_q          <= '0;
      multi_write_count_q  <= '0;
      unwritten_count_q    <= '0;
      first_err_valid_q    <= 1'b0;
      first_err_address_q  <= '0;
      first_err_data_q     <= '0;
      first_err_expected_q <= '0;
      halt_q               <= 1'b0;
    end else begin
      state_q              <= state_d;
      addr_q               <= addr_d;
      tail_q               <= tail_d;
      drain_q              <= drain_d;
      sw_valid_q           <= sw_valid_d;
      s1_valid_q           <= s1_valid_d;
      s1_inr_q             <= s1_inr_d;
      s1_addr_q            <= s1_addr_d;
      s1_data_q            <= s1_data_d;
      fwd_q                <= fwd_d;
      fwd_cnt_q            <= fwd_cnt_d;
      mismatch_count_q     <= mismatch_count_d;
      oor_count_q          <= oor_count_d;
      multi_write_count_q  <= multi_write_count_d;
      unwritten_count_q    <= unwritten_count_d;
      first_err_valid_q    <= first_err_valid_d;
      first_err_address_q  <= first_err_address_d;
      first_err_data_q     <= first_err_data_d;
      first_err_expected_q <= first_err_expected_d;
      halt_q               <= halt_d;
    end
  end
  assign busy               = state_q inside {S_MON_CLEAR, S_MON_MONITOR, S_MON_SWEEP};
  assign report_valid       = state_q == S_MON_REPORT;
  assign mismatch_count     = mismatch_count_q;
  assign oor_count          = oor_count_q;
  assign multi_write_count  = multi_write_count_q;
  assign unwritten_count    = unwritten_count_q;
  assign first_err_valid    = first_err_valid_q;
  assign first_err_address  = first_err_address_q;
  assign first_err_data     = first_err_data_q;
  assign first_err_expected = first_err_expected_q;
  assign halt               = halt_q;
endmodule
